// File: rtl/int_square.sv
// Sequential integer squarer with remainder add: n = q*q + r, one radix-2
// shift-add step per cycle, MSB of q first. Inverse of the square-root unit.
module int_square #(
   parameter int WIDTH = 24
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic [WIDTH/2-1:0]   q_i,
   input  logic [WIDTH/2:0]     r_i,
   output logic [WIDTH-1:0]     n_o,
   output logic                 err_o,
   output logic                 busy_o,
   output logic                 valid_o
);

   localparam int HALF  = WIDTH / 2;
   localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_reg, state_next;
   logic [HALF-1:0]      q_reg;
   logic [HALF:0]        r_reg;
   logic [WIDTH-1:0]     acc_reg;
   logic [WIDTH-1:0]     acc_next;
   logic [WIDTH-1:0]     addend;
   logic [CNT_W-1:0]     cnt_reg;
   logic                 err_reg;
   logic [WIDTH-1:0]     n_reg;
   logic                 err_out_reg;
   logic                 valid_reg;
   logic                 cur_bit;
   logic                 err_in;

   assign cur_bit = q_reg[cnt_reg];

   // Partial product for this step: q gated by the current root bit.
   genvar gi;
   generate
      for (gi = 0; gi < HALF; gi++) begin : g_addend_lo
         assign addend[gi] = q_reg[gi] & cur_bit;
      end
      for (gi = HALF; gi < WIDTH; gi++) begin : g_addend_hi
         assign addend[gi] = 1'b0;
      end
   endgenerate

   assign acc_next = {acc_reg[WIDTH-2:0], 1'b0} + addend;
   assign err_in   = r_i > {q_i, 1'b0};

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start_i) state_next = RUN;
         RUN:     if (cnt_reg == '0) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         q_reg       <= '0;
         r_reg       <= '0;
         acc_reg     <= '0;
         cnt_reg     <= '0;
         err_reg     <= 1'b0;
         n_reg       <= '0;
         err_out_reg <= 1'b0;
         valid_reg   <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start_i) begin
                  q_reg   <= q_i;
                  r_reg   <= r_i;
                  acc_reg <= '0;
                  cnt_reg <= CNT_W'(HALF - 1);
                  err_reg <= err_in;
               end
            end
            RUN: begin
               acc_reg <= acc_next;
               if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end
            end
            DONE: begin
               // Wraps only for non-canonical remainders (err set).
               n_reg       <= acc_reg + {{(WIDTH-HALF-1){1'b0}}, r_reg};
               err_out_reg <= err_reg;
               valid_reg   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign n_o     = n_reg;
   assign err_o   = err_out_reg;
   assign busy_o  = (state_reg != IDLE);
   assign valid_o = valid_reg;

endmodule

// File: tb/tb_int_square.sv
// Scoreboard bench for int_square (WIDTH=24): expected results queued at
// start, checked with latency, hold and busy behaviour as results emerge.
module tb_int_square;

   localparam int WIDTH = 24;
   localparam int LAT   = WIDTH / 2 + 1;

   typedef struct {
      logic [WIDTH-1:0] n;
      logic             err;
      int               edge_no;
   } exp_t;

   logic                 clk;
   logic                 reset_i;
   logic                 start_i;
   logic [WIDTH/2-1:0]   q_i;
   logic [WIDTH/2:0]     r_i;
   logic [WIDTH-1:0]     n_o;
   logic                 err_o;
   logic                 busy_o;
   logic                 valid_o;

   int   cyc;
   int   n_cmp;
   int   n_bad;
   int   run_start;
   int   last_acc;
   logic mon_en;
   logic [WIDTH-1:0] held_n;
   logic held_err;
   exp_t sb[$];
   exp_t mon_e;

   int_square #(.WIDTH(WIDTH)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .start_i (start_i),
      .q_i     (q_i),
      .r_i     (r_i),
      .n_o     (n_o),
      .err_o   (err_o),
      .busy_o  (busy_o),
      .valid_o (valid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic wait_edge(input int e);
      while (cyc < e) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Issue a request that must be accepted; waits until the DUT is free.
   task automatic send(input int q, input int r);
      int unsigned full;
      exp_t e;
      wait_edge(last_acc + LAT);
      q_i     = 12'(q);
      r_i     = 13'(r);
      start_i = 1'b1;
      full      = 32'(q * q + r);
      e.n       = full[WIDTH-1:0];
      e.err     = (r > 2 * q);
      e.edge_no = cyc + 1;
      sb.push_back(e);
      run_start = cyc + 1;
      last_acc  = cyc + 1;
      $display("start q=%0d r=%0d -> expect n=%0d err=%0d at edge %0d", q, r, e.n, e.err, e.edge_no + LAT);
      @(posedge clk);
      #1;
      start_i = 1'b0;
      q_i     = 12'($urandom);
      r_i     = 13'($urandom);
   endtask

   // Request issued while busy: must be ignored, so nothing is queued.
   task automatic pulse_ignored(input int q, input int r);
      q_i     = 12'(q);
      r_i     = 13'(r);
      start_i = 1'b1;
      $display("ignored start q=%0d r=%0d while busy", q, r);
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (valid_o) begin
            if (sb.size() == 0) begin
               check_val("unexpected_valid", 32'(valid_o), 32'd0);
            end else begin
               mon_e = sb.pop_front();
               check_val("n", 32'(n_o), 32'(mon_e.n));
               check_val("err", 32'(err_o), 32'(mon_e.err));
               check_val("latency", cyc, mon_e.edge_no + LAT);
               held_n   = mon_e.n;
               held_err = mon_e.err;
               $display("result n=%0d err=%0d at edge %0d", n_o, err_o, cyc);
            end
         end
         check_val("busy", 32'(busy_o), 32'((cyc >= run_start) && (cyc < run_start + LAT)));
         check_val("n_hold", 32'(n_o), 32'(held_n));
         check_val("err_hold", 32'(err_o), 32'(held_err));
      end
   end

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      run_start = -1000;
      last_acc  = -1000;
      mon_en    = 1'b0;
      held_n    = '0;
      held_err  = 1'b0;
      reset_i   = 1'b1;
      start_i   = 1'b0;
      q_i       = '0;
      r_i       = '0;
      repeat (3) @(posedge clk);
      #1;
      reset_i = 1'b0;
      @(negedge clk);
      check_val("rst_n", 32'(n_o), 32'd0);
      check_val("rst_err", 32'(err_o), 32'd0);
      check_val("rst_busy", 32'(busy_o), 32'd0);
      check_val("rst_valid", 32'(valid_o), 32'd0);
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      send(4095, 8190);
      send(1000, 0);
      send(1234, 100);
      send(3, 7);
      send(4095, 8191);
      send(0, 0);

      // Start while busy is dropped; next start lands in the valid cycle.
      send(5, 0);
      wait_edge(last_acc + 3);
      pulse_ignored(9, 0);
      send(9, 0);

      // Reset mid-run aborts without a result.
      send(100, 0);
      wait_edge(last_acc + 5);
      reset_i = 1'b1;
      @(posedge clk);
      #1;
      reset_i   = 1'b0;
      sb.delete();
      run_start = -1000;
      last_acc  = -1000;
      held_n    = '0;
      held_err  = 1'b0;
      $display("reset mid-run");
      @(negedge clk);
      check_val("abort_n", 32'(n_o), 32'd0);
      check_val("abort_busy", 32'(busy_o), 32'd0);
      @(posedge clk);
      #1;
      send(7, 2);

      for (int i = 0; i < 6; i++) begin
         int q;
         q = int'($urandom_range(4095));
         send(q, int'($urandom_range(2 * q)));
      end

      for (int i = 0; i < 300 && sb.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      if (sb.size() != 0) check_val("drain_timeout", 32'(sb.size()), 32'd0);
      repeat (20) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/int_square.md
Name: int_square

Overview:
- Sequential integer squarer with remainder add: computes n_o = q_i*q_i + r_i over WIDTH/2 cycles using radix-2 shift-add.
- Inverse of the integer square-root unit. Feeding its q/r outputs back through this block must reproduce the original radicand.
- Used in the FPU sqrt path for result checking and for reconstructing the radicand. Uses the same start/valid pulse handshake as the other iterative arithmetic blocks.

Parameters:
- WIDTH, 24, result width. Must be even and ≥4. The root operand is WIDTH/2 bits.

Ports:
- clk_i  input  1  clock. All logic is on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- start_i  input  1  single-cycle request. Sampled only in IDLE.
- q_i  input  WIDTH/2  root operand. Sampled in the start cycle.
- r_i  input  WIDTH/2+1  remainder operand. Sampled in the start cycle.
- n_o  output  WIDTH  result q*q + r, truncated to WIDTH bits. Registered and held.
- err_o  output  1  set when r_i > 2*q_i (non-canonical remainder). Registered, updates with n_o.
- busy_o  output  1  high whenever state != IDLE.
- valid_o  output  1  one-cycle pulse marking n_o/err_o as updated.

Behaviour:
- Reset (reset_i=1 at an edge): state=IDLE; n_o=0, err_o=0, valid_o=0, busy_o=0; internal accumulator, operands and counter cleared. Reset has priority over everything and aborts a run in progress; no valid_o is produced for the aborted request.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start_i=1. Otherwise stay in IDLE.
  - RUN→DONE at the edge where cnt==0. Otherwise stay in RUN and decrement cnt.
  - DONE→IDLE unconditionally.
- At the accepting edge (IDLE, start_i=1):
  - latch q_reg=q_i, r_reg=r_i;
  - acc=0, cnt=WIDTH/2-1;
  - err_reg = (r_i > {q_i,1'b0}), compared at WIDTH/2+1 bits.
- Each RUN edge: acc = (acc<<1) + (q_reg[cnt] ? q_reg : 0). acc is WIDTH bits and cannot overflow because q² < 2^WIDTH. This is WIDTH/2 iterations total, MSB first.
- DONE edge:
  - n_o = acc + zero-extended r_reg, truncated to WIDTH bits (wraps on overflow, which is only possible when err=1);
  - err_o = err_reg;
  - valid_o = 1.
- All other edges: valid_o = 0; n_o and err_o hold.
- Latency: start_i sampled at edge t → valid_o high for exactly one cycle following edge t+WIDTH/2+1. For WIDTH=24 this is 13 edges. busy_o is high for cycles t+1 … t+WIDTH/2+1.
- start_i while busy_o=1 is ignored: no queueing and no operand change.
- start_i in the cycle where valid_o=1: the FSM is in IDLE, so the request is accepted (back-to-back throughput of one result per WIDTH/2+2 cycles). The previous n_o is held until the new DONE.
- Operand changes on q_i/r_i after the start cycle have no effect.
- q_i=0: the run still takes the full WIDTH/2 cycles. Result is n_o = r_i; err_o = (r_i != 0).
- Canonical inputs (r ≤ 2q) never wrap: maximum n = (2^(W/2)-1)² + 2(2^(W/2)-1) = 2^W-1.

Test Plan:
- WIDTH=24: q_i=4095, r_i=8190, start pulse → valid_o exactly 13 edges later; n_o=16777215, err_o=0; busy_o low again the cycle after valid_o.
- q_i=1000, r_i=0 → n_o=1000000, err_o=0. Also q_i=1234, r_i=100 → n_o=1522856, err_o=0.
- q_i=3, r_i=7 (7>6) → n_o=16, err_o=1. Also q_i=4095, r_i=8191 → n_o=0 (wrap), err_o=1.
- q_i=0, r_i=0 → n_o=0, err_o=0 with full 13-edge latency.
- Start q=5,r=0; pulse start_i with q=9 at cycle 4 while busy → single valid_o, n_o=25. Then start q=9 in the valid_o cycle → second valid_o 13 edges later, n_o=81; n_o holds 25 in between.
- Start q=100, assert reset_i at cycle 6 → all outputs 0, no valid_o. Start q=7,r=2 after reset release → n_o=51, normal latency.
